// File: rtl/hs_cdc_data_rx.sv
// hs_cdc_data_rx: receive side of a 4-phase req/ack bundled-data CDC link with a one-entry valid/ready output buffer
// Ports:
//   i_clk_b, i_rst        receive clock, async active-high reset
//   i_req, i_data         request and bundled word from the clk_a domain
//   o_ack                 flopped acknowledge back to the clk_a domain
//   o_rx_data, o_rx_valid, i_rx_ready   one-entry output buffer handshake
//   o_xfer_cnt            words captured since reset (wraps)
//   o_busy                FSM is in ACK
module hs_cdc_data_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk_b,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic [DW-1:0]    i_data,
    output logic             o_ack,
    output logic [DW-1:0]    o_rx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic [CNT_W-1:0] o_xfer_cnt,
    output logic             o_busy
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ack;
    logic                   r_busy;
    logic                   r_valid;
    logic [DW-1:0]          r_data;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_req_s;
    logic                   w_drain;
    logic                   w_space;
    logic                   w_capture;
    assign w_req_s   = r_sync[SYNC_STAGES-1];
    assign w_drain   = r_valid & i_rx_ready;
    assign w_space   = ~r_valid | w_drain;
    // i_data is only sampled here, after req_s has been high long enough for the bundle to settle
    assign w_capture = (r_state == IDLE) & w_req_s & w_space;
    always_ff @(posedge i_clk_b or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
            if (w_capture) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
                r_cnt   <= r_cnt + 1'b1;
                r_ack   <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= ACK;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
            // ack is held until req is withdrawn, so a held-high req yields one word only
            if (r_state == ACK && !w_req_s) begin
                r_ack   <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end
        end
    end
    assign o_ack      = r_ack;
    assign o_busy     = r_busy;
    assign o_rx_valid = r_valid;
    assign o_rx_data  = r_data;
    assign o_xfer_cnt = r_cnt;
endmodule

// File: tb/tb_hs_cdc_data_rx.sv
// tb_hs_cdc_data_rx: scoreboard bench for hs_cdc_data_rx with a 2x clk_a transmitter model
`timescale 1ns/1ps
module tb_hs_cdc_data_rx;
    logic        clk_b = 0;
    logic        clk_a = 0;
    logic        rst = 1;
    logic        req = 0;
    logic [7:0]  data = 0;
    logic        rx_ready = 0;
    logic        ack, rx_valid, busy;
    logic [7:0]  rx_data;
    logic [15:0] xfer_cnt;
    logic        ack4, rx_valid4, busy4;
    logic [7:0]  rx_data4;
    logic [3:0]  xfer_cnt4;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cnt_model = 0;
    logic [7:0]  sb_q[$];
    hs_cdc_data_rx dut (
        .i_clk_b(clk_b), .i_rst(rst), .i_req(req), .i_data(data),
        .o_ack(ack), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .i_rx_ready(rx_ready), .o_xfer_cnt(xfer_cnt), .o_busy(busy)
    );
    hs_cdc_data_rx #(.CNT_W(4)) dut4 (
        .i_clk_b(clk_b), .i_rst(rst), .i_req(req), .i_data(data),
        .o_ack(ack4), .o_rx_data(rx_data4), .o_rx_valid(rx_valid4),
        .i_rx_ready(rx_ready), .o_xfer_cnt(xfer_cnt4), .o_busy(busy4)
    );
    always #5 clk_b = ~clk_b;
    initial begin
        #1;
        forever #2.5 clk_a = ~clk_a;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk_b) begin
        if (!rst && rx_valid && rx_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected_word", 0, 1);
            else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                chk("rx_data", rx_data, e);
                chk("rx_data_cnt4", rx_data4, e);
            end
        end
    end
    task automatic wait_ack_b(input logic lvl, input string tag);
        for (int i = 0; i < 50 && ack !== lvl; i++) begin
            @(posedge clk_b);
            #1;
        end
        chk(tag, ack, lvl);
    endtask
    task automatic send(input logic [7:0] w);
        @(posedge clk_a);
        data = w;
        sb_q.push_back(w);
        req = 1;
        for (int i = 0; i < 100 && !ack; i++) @(posedge clk_a);
        chk("send_ack_rise", ack, 1);
        cnt_model++;
        chk("send_cnt", xfer_cnt, cnt_model % 65536);
        chk("send_cnt4", xfer_cnt4, cnt_model % 16);
        req = 0;
        for (int i = 0; i < 100 && ack; i++) @(posedge clk_a);
        chk("send_ack_fall", ack, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int drops, c0;
        repeat (3) @(posedge clk_b);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_cnt", xfer_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        rx_ready = 1;
        // single transfer with exact edge latency
        @(posedge clk_b);
        #1;
        req = 1;
        data = 8'hA5;
        sb_q.push_back(8'hA5);
        @(posedge clk_b); #1 chk("lat_e1_ack", ack, 0);
        @(posedge clk_b); #1 chk("lat_e2_ack", ack, 0);
        @(posedge clk_b); #1 chk("lat_e3_ack", ack, 1);
        cnt_model++;
        chk("single_data", rx_data, 8'hA5);
        chk("single_valid", rx_valid, 1);
        chk("single_cnt", xfer_cnt, 1);
        chk("single_busy", busy, 1);
        req = 0;
        @(posedge clk_b); #1 chk("fall_m_ack", ack, 1);
        @(posedge clk_b); #1 chk("fall_m1_ack", ack, 1);
        @(posedge clk_b); #1 chk("fall_m2_ack", ack, 0);
        chk("fall_busy", busy, 0);
        chk("hold_valid", rx_valid, 0);
        chk("hold_data", rx_data, 8'hA5);
        // back-to-back stream from the clk_a side
        for (int w = 0; w < 16; w++) send(8'(w));
        repeat (4) @(posedge clk_b);
        #1;
        chk("b2b_sb_empty", sb_q.size(), 0);
        chk("b2b_cnt", xfer_cnt, 17);
        chk("wrap_cnt4", xfer_cnt4, 1);
        // back-pressure
        rx_ready = 0;
        send(8'h11);
        @(posedge clk_b);
        #1;
        req = 1;
        data = 8'h22;
        sb_q.push_back(8'h22);
        repeat (6) @(posedge clk_b);
        #1;
        chk("bp_ack_low", ack, 0);
        chk("bp_data_held", rx_data, 8'h11);
        chk("bp_valid", rx_valid, 1);
        chk("bp_cnt", xfer_cnt, cnt_model);
        rx_ready = 1;
        @(posedge clk_b);
        #1;
        rx_ready = 0;
        cnt_model++;
        chk("bp_swap_data", rx_data, 8'h22);
        chk("bp_swap_valid", rx_valid, 1);
        chk("bp_swap_ack", ack, 1);
        chk("bp_swap_cnt", xfer_cnt, cnt_model);
        req = 0;
        wait_ack_b(0, "bp_ack_fall");
        rx_ready = 1;
        repeat (3) @(posedge clk_b);
        #1;
        chk("bp_sb_empty", sb_q.size(), 0);
        // held req produces one word only
        req = 1;
        data = 8'h33;
        sb_q.push_back(8'h33);
        wait_ack_b(1, "held_ack_rise");
        cnt_model++;
        c0 = cnt_model;
        drops = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_b);
            #1;
            if (!ack) drops++;
        end
        chk("held_ack_drops", drops, 0);
        chk("held_cnt", xfer_cnt, c0);
        chk("held_sb_empty", sb_q.size(), 0);
        req = 0;
        wait_ack_b(0, "held_ack_fall");
        // asynchronous reset mid-handshake
        rx_ready = 0;
        req = 1;
        data = 8'h77;
        sb_q.push_back(8'h77);
        wait_ack_b(1, "mid_ack_rise");
        @(posedge clk_b);
        #3;
        rst = 1;
        #1;
        chk("arst_ack", ack, 0);
        chk("arst_valid", rx_valid, 0);
        chk("arst_cnt", xfer_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", rx_data, 0);
        sb_q.delete();
        cnt_model = 0;
        req = 0;
        @(posedge clk_b);
        #1;
        rst = 0;
        rx_ready = 1;
        send(8'h5A);
        repeat (3) @(posedge clk_b);
        #1;
        chk("post_rst_sb_empty", sb_q.size(), 0);
        chk("post_rst_cnt", xfer_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
